// File: rtl/inst_queue.sv
// Dual-slot in-order instruction queue between decode and issue (circular buffer).
// Latency: an entry written on edge N is visible at the dequeue outputs in cycle N+1.
// Backpressure: enq_ready_o drops when fewer than two entries are free; a refused pair is held upstream.
`ifndef CTRL_BUS
`define CTRL_BUS 16
`endif

module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 enq_valid0_i,
    input  logic                 enq_valid1_i,
    input  logic [31:0]          enq_inst0_i,
    input  logic [31:0]          enq_inst1_i,
    input  logic [`CTRL_BUS-1:0] enq_ctrl0_i,
    input  logic [`CTRL_BUS-1:0] enq_ctrl1_i,
    input  logic                 enq_pred0_i,
    input  logic                 enq_pred1_i,
    input  logic [31:0]          enq_pred_tgt0_i,
    input  logic [31:0]          enq_pred_tgt1_i,
    input  logic [31:0]          enq_pc0_i,
    input  logic [31:0]          enq_pc1_i,
    output logic                 enq_ready_o,
    input  logic [1:0]           deq_take_i,
    output logic                 deq_valid0_o,
    output logic                 deq_valid1_o,
    output logic [31:0]          deq_inst0_o,
    output logic [31:0]          deq_inst1_o,
    output logic [`CTRL_BUS-1:0] deq_ctrl0_o,
    output logic [`CTRL_BUS-1:0] deq_ctrl1_o,
    output logic                 deq_pred0_o,
    output logic                 deq_pred1_o,
    output logic [31:0]          deq_pred_tgt0_o,
    output logic [31:0]          deq_pred_tgt1_o,
    output logic [31:0]          deq_pc0_o,
    output logic [31:0]          deq_pc1_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - 2);
    localparam logic [31:0]      NOP_INST  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]          inst;
        logic [`CTRL_BUS-1:0] ctrl;
        logic                 pred;
        logic [31:0]          pred_tgt;
        logic [31:0]          pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CNT_W-1:0] count;

    entry_t        e0, e1, h0, h1;
    logic          do_enq;
    logic [1:0]    n_enq, avail, take_eff;
    logic [PW-1:0] head1, tail1, slot1_ptr;

    assign e0 = '{inst: enq_inst0_i, ctrl: enq_ctrl0_i, pred: enq_pred0_i,
                  pred_tgt: enq_pred_tgt0_i, pc: enq_pc0_i};
    assign e1 = '{inst: enq_inst1_i, ctrl: enq_ctrl1_i, pred: enq_pred1_i,
                  pred_tgt: enq_pred_tgt1_i, pc: enq_pc1_i};

    assign enq_ready_o = (count <= ENQ_LIMIT);
    assign do_enq      = enq_ready_o && !flush_i;
    assign n_enq       = do_enq ? ({1'b0, enq_valid0_i} + {1'b0, enq_valid1_i}) : 2'd0;

    assign head1     = head + PW'(1);
    assign tail1     = tail + PW'(1);
    // A lone slot-1 entry is compacted down to the tail position.
    assign slot1_ptr = enq_valid0_i ? tail1 : tail;

    assign deq_valid0_o = (count >= CNT_W'(1));
    assign deq_valid1_o = (count >= CNT_W'(2));
    assign avail        = deq_valid1_o ? 2'd2 : {1'b0, deq_valid0_o};
    assign take_eff     = (deq_take_i > avail) ? avail : deq_take_i;
    assign count_o      = count;

    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(take_eff);
            tail  <= tail + PW'(n_enq);
            count <= count + CNT_W'(n_enq) - CNT_W'(take_eff);
        end
    end

    // Storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge clock_i) begin
        if (!reset_i && do_enq) begin
            if (enq_valid0_i) mem[tail]      <= e0;
            if (enq_valid1_i) mem[slot1_ptr] <= e1;
        end
    end

    assign h0 = mem[head];
    assign h1 = mem[head1];

    always_comb begin
        deq_inst0_o     = NOP_INST;
        deq_ctrl0_o     = '0;
        deq_pred0_o     = 1'b0;
        deq_pred_tgt0_o = '0;
        deq_pc0_o       = '0;
        deq_inst1_o     = NOP_INST;
        deq_ctrl1_o     = '0;
        deq_pred1_o     = 1'b0;
        deq_pred_tgt1_o = '0;
        deq_pc1_o       = '0;
        if (deq_valid0_o) begin
            deq_inst0_o     = h0.inst;
            deq_ctrl0_o     = h0.ctrl;
            deq_pred0_o     = h0.pred;
            deq_pred_tgt0_o = h0.pred_tgt;
            deq_pc0_o       = h0.pc;
        end
        if (deq_valid1_o) begin
            deq_inst1_o     = h1.inst;
            deq_ctrl1_o     = h1.ctrl;
            deq_pred1_o     = h1.pred;
            deq_pred_tgt1_o = h1.pred_tgt;
            deq_pc1_o       = h1.pc;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed vector table plus a streaming sequence for the DEPTH=4 instruction queue.
module tb_inst_queue;

    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        reset, flush, v0, v1;
    logic [31:0] i0, i1, t0, t1, p0, p1;
    logic [CW-1:0] c0, c1;
    logic        pr0, pr1;
    logic [1:0]  take;
    logic        rdy, dv0, dv1;
    logic [31:0] di0, di1, dt0, dt1, dp0, dp1;
    logic [CW-1:0] dc0, dc1;
    logic        dpr0, dpr1;
    logic [2:0]  cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(4)) dut (
        .clock_i(clk), .reset_i(reset), .flush_i(flush),
        .enq_valid0_i(v0), .enq_valid1_i(v1),
        .enq_inst0_i(i0), .enq_inst1_i(i1),
        .enq_ctrl0_i(c0), .enq_ctrl1_i(c1),
        .enq_pred0_i(pr0), .enq_pred1_i(pr1),
        .enq_pred_tgt0_i(t0), .enq_pred_tgt1_i(t1),
        .enq_pc0_i(p0), .enq_pc1_i(p1),
        .enq_ready_o(rdy), .deq_take_i(take),
        .deq_valid0_o(dv0), .deq_valid1_o(dv1),
        .deq_inst0_o(di0), .deq_inst1_o(di1),
        .deq_ctrl0_o(dc0), .deq_ctrl1_o(dc1),
        .deq_pred0_o(dpr0), .deq_pred1_o(dpr1),
        .deq_pred_tgt0_o(dt0), .deq_pred_tgt1_o(dt1),
        .deq_pc0_o(dp0), .deq_pc1_o(dp1),
        .count_o(cnt)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction
    function automatic logic [CW-1:0] ctrl_of(input logic [31:0] pc);
        return pc[15:0] | 16'h8000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic a, input logic b,
                         input logic [31:0] pa, input logic [31:0] pb, input logic [1:0] tk);
        reset = r; flush = f; v0 = a; v1 = b; take = tk;
        p0 = pa; p1 = pb;
        i0 = inst_of(pa); i1 = inst_of(pb);
        c0 = ctrl_of(pa); c1 = ctrl_of(pb);
        pr0 = pa[2]; pr1 = pb[2];
        t0 = pa + 32'h1000; t1 = pb + 32'h1000;
    endtask

    typedef struct {
        logic        rst, fl, a, b;
        logic [31:0] pa, pb;
        logic [1:0]  tk;
        logic [2:0]  e_cnt;
        logic        e_v0, e_v1, e_rdy;
        logic [31:0] e_pc0, e_pc1;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic fl, input logic a, input logic b,
                                input logic [31:0] pa, input logic [31:0] pb, input logic [1:0] tk,
                                input logic [2:0] e_cnt, input logic e_v0, input logic e_v1,
                                input logic e_rdy, input logic [31:0] e_pc0, input logic [31:0] e_pc1);
        vec_t v;
        v.rst = rst; v.fl = fl; v.a = a; v.b = b; v.pa = pa; v.pb = pb; v.tk = tk;
        v.e_cnt = e_cnt; v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_rdy = e_rdy;
        v.e_pc0 = e_pc0; v.e_pc1 = e_pc1;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        //            rst  fl   v0   v1   pc0    pc1    take  cnt  dv0  dv1  rdy  exp pc0 exp pc1
        vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,32'h000,32'h000,2'd0, 3'd0,1'b0,1'b0,1'b1,32'h000,32'h000);
        vecs[1]  = mk(1'b0,1'b0,1'b1,1'b1,32'h100,32'h104,2'd0, 3'd2,1'b1,1'b1,1'b1,32'h100,32'h104);
        vecs[2]  = mk(1'b0,1'b0,1'b1,1'b1,32'h108,32'h10C,2'd1, 3'd3,1'b1,1'b1,1'b0,32'h104,32'h108);
        vecs[3]  = mk(1'b0,1'b0,1'b1,1'b1,32'h110,32'h114,2'd0, 3'd3,1'b1,1'b1,1'b0,32'h104,32'h108);
        vecs[4]  = mk(1'b0,1'b0,1'b0,1'b0,32'h000,32'h000,2'd2, 3'd1,1'b1,1'b0,1'b1,32'h10C,32'h000);
        vecs[5]  = mk(1'b0,1'b0,1'b1,1'b1,32'h110,32'h114,2'd0, 3'd3,1'b1,1'b1,1'b0,32'h10C,32'h110);
        vecs[6]  = mk(1'b0,1'b1,1'b1,1'b1,32'h200,32'h204,2'd1, 3'd0,1'b0,1'b0,1'b1,32'h000,32'h000);
        vecs[7]  = mk(1'b0,1'b0,1'b0,1'b1,32'h000,32'h300,2'd0, 3'd1,1'b1,1'b0,1'b1,32'h300,32'h000);
        vecs[8]  = mk(1'b1,1'b1,1'b1,1'b1,32'h350,32'h354,2'd2, 3'd0,1'b0,1'b0,1'b1,32'h000,32'h000);
        vecs[9]  = mk(1'b0,1'b0,1'b1,1'b1,32'h400,32'h404,2'd2, 3'd2,1'b1,1'b1,1'b1,32'h400,32'h404);
        vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,32'h000,32'h000,2'd2, 3'd0,1'b0,1'b0,1'b1,32'h000,32'h000);
        vecs[11] = mk(1'b0,1'b0,1'b1,1'b0,32'h500,32'h000,2'd0, 3'd1,1'b1,1'b0,1'b1,32'h500,32'h000);
        vecs[12] = mk(1'b0,1'b0,1'b1,1'b1,32'h504,32'h508,2'd2, 3'd2,1'b1,1'b1,1'b1,32'h504,32'h508);

        @(negedge clk);
        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].rst, vecs[k].fl, vecs[k].a, vecs[k].b, vecs[k].pa, vecs[k].pb, vecs[k].tk);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d count", k), 32'(cnt), 32'(vecs[k].e_cnt));
            chk($sformatf("v%0d valid0", k), 32'(dv0), 32'(vecs[k].e_v0));
            chk($sformatf("v%0d valid1", k), 32'(dv1), 32'(vecs[k].e_v1));
            chk($sformatf("v%0d ready", k), 32'(rdy), 32'(vecs[k].e_rdy));
            if (vecs[k].e_v0) begin
                chk($sformatf("v%0d pc0", k), dp0, vecs[k].e_pc0);
                chk($sformatf("v%0d inst0", k), di0, inst_of(vecs[k].e_pc0));
            end else begin
                chk($sformatf("v%0d bubble inst0", k), di0, 32'h0000_0013);
                chk($sformatf("v%0d bubble ctrl0", k), 32'(dc0), 32'h0);
                chk($sformatf("v%0d bubble pred0", k), 32'(dpr0), 32'h0);
            end
            if (vecs[k].e_v1) begin
                chk($sformatf("v%0d pc1", k), dp1, vecs[k].e_pc1);
                chk($sformatf("v%0d ctrl1", k), 32'(dc1), 32'(ctrl_of(vecs[k].e_pc1)));
            end else begin
                chk($sformatf("v%0d bubble inst1", k), di1, 32'h0000_0013);
                chk($sformatf("v%0d bubble ctrl1", k), 32'(dc1), 32'h0);
            end
        end

        // Streaming: 20 pairs in, alternating take 2/1, dequeued pcs must run +4 across wraps.
        begin
            logic [31:0] next_in, exp_out;
            int          got, cyc;
            logic [1:0]  tk;
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
            @(posedge clk);
            @(negedge clk);
            next_in = 32'h1000;
            exp_out = 32'h1000;
            got     = 0;
            cyc     = 0;
            tk      = 2'd2;
            while (got < 40 && cyc < 400) begin
                if (next_in < 32'h1000 + 32'd160)
                    drive(1'b0, 1'b0, 1'b1, 1'b1, next_in, next_in + 32'd4, tk);
                else
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, tk);
                if (tk >= 2'd1 && dv0) begin
                    chk("stream pc0", dp0, exp_out);
                    chk("stream ctrl0", 32'(dc0), 32'(ctrl_of(exp_out)));
                    exp_out += 32'd4;
                    got++;
                end
                if (tk == 2'd2 && dv1) begin
                    chk("stream pc1", dp1, exp_out);
                    exp_out += 32'd4;
                    got++;
                end
                if (rdy && v0) next_in += 32'd8;
                @(posedge clk);
                @(negedge clk);
                tk = (tk == 2'd2) ? 2'd1 : 2'd2;
                cyc++;
            end
            chk("stream entries received", 32'(got), 32'd40);
            chk("stream drained count", 32'(cnt), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of entries; it SHALL be a power of two and at least 4.
REQ-002 clock_i  in  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-003 reset_i  in  1  SHALL be a synchronous, active-high reset.
REQ-004 flush_i  in  1  SHALL discard all entries (redirect or mispredict).
REQ-005 enq_valid0_i, enq_valid1_i  in  1 each  SHALL mark the decoded slot 0 and slot 1 entries as present.
REQ-006 enq_inst0_i/enq_inst1_i (32), enq_ctrl0_i/enq_ctrl1_i (`CTRL_BUS), enq_pred0_i/enq_pred1_i (1), enq_pred_tgt0_i/enq_pred_tgt1_i (32), enq_pc0_i/enq_pc1_i (32)  in  SHALL carry the entry payloads.
REQ-007 enq_ready_o  out  1  SHALL be high when the queue accepts an enqueue this cycle.
REQ-008 deq_take_i  in  2  SHALL give the number of head entries the issue stage consumes this cycle: 0, 1 or 2.
REQ-009 deq_valid0_o, deq_valid1_o  out  1 each  SHALL mark the head entry and the head+1 entry as valid.
REQ-010 deq_inst0_o/deq_inst1_o, deq_ctrl0_o/deq_ctrl1_o, deq_pred0_o/deq_pred1_o, deq_pred_tgt0_o/deq_pred_tgt1_o, deq_pc0_o/deq_pc1_o  out  SHALL carry the head and head+1 payloads, with the same widths as REQ-006.
REQ-011 count_o  out  log2(DEPTH)+1  SHALL give the number of occupied entries.

Function
REQ-012 Storage SHALL be a circular buffer with head and tail pointers of log2(DEPTH) bits and an occupancy counter; both pointers SHALL wrap modulo DEPTH.
REQ-013 enq_ready_o SHALL be (count_o <= DEPTH-2) and SHALL be computed from registered state only, never from deq_take_i.
REQ-014 When enq_ready_o is high and flush_i is low, the present entries SHALL be written at tail, then tail+1, in slot order; a lone enq_valid1_i SHALL be compacted and written at tail.
REQ-015 Enqueue attempts while enq_ready_o is low SHALL be ignored; the upstream stage holds its entries.
REQ-016 Dequeue outputs SHALL be read combinationally from head and head+1; an entry written in cycle N SHALL appear at the outputs in cycle N+1.
REQ-017 deq_valid0_o SHALL equal (count_o >= 1) and deq_valid1_o SHALL equal (count_o >= 2).
REQ-018 When an output slot is invalid, its ctrl output SHALL be all-zero (bubble), its inst output SHALL be 32'h00000013, and its pred output SHALL be 0.
REQ-019 The effective take SHALL be min(deq_take_i, number of valid output slots); head SHALL advance by the effective take.
REQ-020 Simultaneous enqueue and dequeue SHALL be supported: next count = count + enqueued - effective take, with no loss and no duplication.
REQ-021 deq_take_i = 1 with two valid slots (issue slot-1 stall) SHALL present the former head+1 entry in slot 0 on the next cycle.
REQ-022 flush_i SHALL, on the next edge, set head = tail = count = 0; enqueue and dequeue in the same cycle SHALL be ignored.
REQ-023 Program order SHALL be preserved: the output slot 0 entry is always older than the output slot 1 entry.

Reset
REQ-024 On a clock edge with reset_i high, head, tail and count SHALL be 0; reset SHALL take priority over flush_i, enqueue and dequeue.
REQ-025 After reset: enq_ready_o = 1, count_o = 0, deq_valid0_o = deq_valid1_o = 0, both ctrl outputs = 0, and both inst outputs = 32'h00000013.
REQ-026 A reset asserted mid-operation SHALL discard all entries; storage contents need not be cleared.

Verification
REQ-027 After reset, enqueue pc 0x100/0x104 with deq_take_i = 0: next cycle deq_valid0_o = deq_valid1_o = 1, deq_pc0_o = 0x100, deq_pc1_o = 0x104, count_o = 2.
REQ-028 With 0x100/0x104 queued, set deq_take_i = 1 while enqueuing 0x108/0x10C: next cycle deq_pc0_o = 0x104, deq_pc1_o = 0x108, count_o = 3.
REQ-029 Fill a DEPTH = 4 queue to 3 entries, then offer a pair: enq_ready_o = 0, count stays 3, and the pair is not stored.
REQ-030 Stream 20 pairs with alternating deq_take_i of 2 and 1: the dequeued pc sequence is strictly +4 with no gaps across pointer wrap.
REQ-031 Assert flush_i with 3 entries queued and a concurrent enqueue: next cycle count_o = 0, both valids = 0, and enq_ready_o = 1.
REQ-032 Assert reset_i and flush_i together with deq_take_i = 2 and 1 entry queued: next cycle count_o = 0, and the outputs match REQ-025.
